uart_transceiver: RTL and testbench
===================================

# uart_transceiver

- Full-duplex 8N1 UART serving the UART slot of the memory-mapped IO block.
- Consumes `baud`, `send` and `DataOut` from the bus-side registers; drives `tx`, `DataIn` and `busy` back to them.
- Uses a fractional baud generator, so any 24-bit baud value works without a hardware divider.
- Receiver uses 16x oversampling.

## Interface
- `CLK_HZ`, default 1_843_200: frequency of `clk_xtal` in Hz.
- `clk_xtal`  in  1  sole clock; all logic on posedge.
- `rst`  in  1  asynchronous, active-high reset.
- `baud`  in  24  bit rate in baud, sampled every cycle.
- `send`  in  1  level request to transmit `DataOut`; passes a 2-flop synchroniser.
- `DataOut`  in  8  byte to transmit; captured at frame start.
- `rx`  in  1  serial input, idle high; passes a 2-flop synchroniser.
- `tx`  out  1  serial output, idle high.
- `DataIn`  out  8  last correctly framed received byte.
- `busy`  out  1  transmitter active.
- `rx_valid`  out  1  one-cycle pulse when `DataIn` updates.
- `rx_err`  out  1  sticky framing error; cleared by the next good byte.

## Operation
- **Tick generator**
  - 32-bit accumulator `acc`; per cycle `inc = baud<<4`.
  - If `acc+inc >= CLK_HZ`: `acc <= acc+inc-CLK_HZ`, `tick=1`. Otherwise `acc <= acc+inc`.
  - If `inc >= CLK_HZ`, tick every cycle and hold `acc` at 0.
  - `baud==0` gives no ticks; both FSMs freeze in place and `busy` holds.
  - A change of `baud` takes effect the next cycle; no frame restart.
- **TX FSM: IDLE, START, DATA, STOP**
  - IDLE with synchronised `send==1`: latch `DataOut` into the shift register, go to START, assert `busy`, set `tx=0`, clear the 4-bit sub-counter.
  - Each state lasts 16 ticks.
  - DATA shifts out LSB first, 8 bits, bit index 0..7.
  - STOP drives `tx=1`. After its 16th tick: IDLE, `busy=0`.
  - `send` is ignored while busy. If `send` is still high on IDLE re-entry, another frame starts (level semantics; the bus side drops `send` once it sees `busy`).
- **RX FSM: IDLE, START, DATA, STOP**
  - IDLE: synchronised `rx` falling edge leads to START with the sub-counter cleared.
  - START: at tick 8, `rx==1` means glitch, return to IDLE. `rx==0` means go to DATA with the sub-counter cleared.
  - DATA: sample at every 16th tick (mid-bit), shifting LSB first; after 8 samples go to STOP.
  - STOP: sample at the 16th tick.
    - `rx==1`: `DataIn <= shift`, pulse `rx_valid`, clear `rx_err`.
    - `rx==0`: `rx_err <= 1`, `DataIn` unchanged, no `rx_valid`.
  - STOP returns to IDLE immediately after the stop-bit sample; the next falling edge is accepted the same cycle.
- TX and RX are independent; simultaneous activity is fully supported.

## Timing
- Reset values: `tx=1`, `busy=0`, `DataIn=8'h00`, `rx_valid=0`, `rx_err=0`, `acc=0`, both FSMs in IDLE.
- Reset mid-frame aborts immediately; `tx` returns high asynchronously.
- `send` rising to `tx` falling: 3 cycles (2 synchroniser + 1 FSM).
- `busy` rises in the same cycle as `tx` falls.
- Frame length is 160 ticks ±1 tick of initial phase; `busy` falls in the cycle after the last stop tick.
- RX latency from the stop-bit mid-sample tick to `rx_valid`: 1 cycle. Add 2 cycles of input synchroniser delay relative to the line.
- `rx_valid` lasts exactly 1 cycle.

## Structure
- Package `uart_pkg`:
  - `uart_state_t` enum {IDLE, START, DATA, STOP}.
  - `OVERSAMPLE = 16`.
  - `DATA_BITS = 8`.
  - `ACC_W = 32`.
- Sub-module `baud_tick_gen` (ports `clk_xtal`, `rst`, `baud`, `tick`; parameter `CLK_HZ`), instanced once and shared by TX and RX.
- TX and RX FSMs live in separate always blocks in the top.

## Test plan
- Reset, then idle at `CLK_HZ=1_843_200`, `baud=115200` (tick every cycle) -> `tx=1`, `busy=0`, `DataIn=0x00`, no `rx_valid` for 1000 cycles.
- `DataOut=0xA5`, `send` pulsed until `busy` seen -> `tx` falls 3 cycles after `send`. `tx` shows start bit, then 1,0,1,0,0,1,0,1, then stop, each exactly 16 cycles. `busy` high for 160 cycles; exactly one frame sent.
- Loop `tx` to `rx`, send `0x3C` -> one `rx_valid` pulse, `DataIn=0x3C`, `rx_err=0`.
- Drive `rx` frame `0x81` with stop bit held low -> `rx_err=1`, `DataIn` keeps its previous value, no `rx_valid`. A following good frame `0x55` -> `DataIn=0x55`, `rx_err=0`.
- 4-cycle low glitch on idle `rx` -> RX returns to IDLE; no `rx_valid`, no `rx_err`.
- Two further cases:
  - `baud=9600`: bit period is 192 cycles ±1.
  - `baud=0` mid-frame: `tx` and `busy` freeze; restoring `baud` resumes the frame.
  - In both: assert `rst` mid-frame -> `tx=1` and `busy=0` immediately.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the 8N1 UART transceiver and its baud tick generator.
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

  localparam int OVERSAMPLE = 16;
  localparam int DATA_BITS  = 8;
  localparam int ACC_W      = 32;

  localparam int SUB_W = $clog2(OVERSAMPLE);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam int OS_SH = $clog2(OVERSAMPLE);

endpackage

// File: rtl/baud_tick_gen.sv
// Fractional baud generator: emits OVERSAMPLE ticks per bit period for any 24-bit baud value.
module baud_tick_gen
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ = 1_843_200
) (
  input  logic        clk_xtal,
  input  logic        rst,
  input  logic [23:0] baud,
  output logic        tick
);

  localparam logic [ACC_W-1:0] CLK_HZ_W = ACC_W'(CLK_HZ);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] inc, sum;

  // acc stays below CLK_HZ and inc < CLK_HZ on the accumulate path, so sum cannot overflow.
  always_comb begin
    inc   = ACC_W'(baud) << OS_SH;
    sum   = acc_q + inc;
    tick  = 1'b0;
    acc_d = sum;
    if (inc >= CLK_HZ_W) begin
      tick  = 1'b1;
      acc_d = '0;
    end else if (sum >= CLK_HZ_W) begin
      tick  = 1'b1;
      acc_d = sum - CLK_HZ_W;
    end
  end

  always_ff @(posedge clk_xtal or posedge rst) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

endmodule

// File: rtl/uart_transceiver.sv
// Full-duplex 8N1 UART: level-triggered transmitter and 16x oversampling receiver sharing one tick.
module uart_transceiver
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ = 1_843_200
) (
  input  logic                 clk_xtal,
  input  logic                 rst,
  input  logic [23:0]          baud,
  input  logic                 send,
  input  logic [DATA_BITS-1:0] DataOut,
  input  logic                 rx,
  output logic                 tx,
  output logic [DATA_BITS-1:0] DataIn,
  output logic                 busy,
  output logic                 rx_valid,
  output logic                 rx_err
);

  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(OVERSAMPLE - 1);
  localparam logic [SUB_W-1:0] SUB_MID  = SUB_W'(OVERSAMPLE / 2 - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  logic tick;

  baud_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
    .clk_xtal (clk_xtal),
    .rst      (rst),
    .baud     (baud),
    .tick     (tick)
  );

  // Input synchronisers; rx_prev_q gives the falling-edge reference for frame start.
  logic send_s1_q, send_s2_q;
  logic rx_s1_q, rx_s2_q, rx_prev_q;

  always_ff @(posedge clk_xtal or posedge rst) begin
    if (rst) begin
      send_s1_q <= 1'b0;
      send_s2_q <= 1'b0;
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      send_s1_q <= send;
      send_s2_q <= send_s1_q;
      rx_s1_q   <= rx;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
    end
  end

  // ---------------- transmitter ----------------
  uart_state_t          tx_st_q, tx_st_d;
  logic [SUB_W-1:0]     tx_cnt_q, tx_cnt_d;
  logic [IDX_W-1:0]     tx_idx_q, tx_idx_d;
  logic [DATA_BITS-1:0] tx_sh_q, tx_sh_d;
  logic                 tx_q, tx_d;

  always_ff @(posedge clk_xtal or posedge rst) begin
    if (rst) begin
      tx_st_q  <= IDLE;
      tx_cnt_q <= '0;
      tx_idx_q <= '0;
      tx_sh_q  <= '0;
      tx_q     <= 1'b1;
    end else begin
      tx_st_q  <= tx_st_d;
      tx_cnt_q <= tx_cnt_d;
      tx_idx_q <= tx_idx_d;
      tx_sh_q  <= tx_sh_d;
      tx_q     <= tx_d;
    end
  end

  // The sub-counter wraps 15->0 on its own, so it only needs clearing at frame start.
  always_comb begin
    tx_st_d  = tx_st_q;
    tx_cnt_d = tx_cnt_q;
    tx_idx_d = tx_idx_q;
    tx_sh_d  = tx_sh_q;
    tx_d     = tx_q;
    case (tx_st_q)
      IDLE: begin
        if (send_s2_q) begin
          tx_st_d  = START;
          tx_sh_d  = DataOut;
          tx_cnt_d = '0;
          tx_d     = 1'b0;
        end
      end
      START: begin
        if (tick) begin
          tx_cnt_d = tx_cnt_q + SUB_W'(1);
          if (tx_cnt_q == SUB_LAST) begin
            tx_st_d  = DATA;
            tx_idx_d = '0;
            tx_d     = tx_sh_q[0];
          end
        end
      end
      DATA: begin
        if (tick) begin
          tx_cnt_d = tx_cnt_q + SUB_W'(1);
          if (tx_cnt_q == SUB_LAST) begin
            if (tx_idx_q == IDX_LAST) begin
              tx_st_d = STOP;
              tx_d    = 1'b1;
            end else begin
              tx_idx_d = tx_idx_q + IDX_W'(1);
              tx_sh_d  = tx_sh_q >> 1;
              tx_d     = tx_sh_q[1];
            end
          end
        end
      end
      STOP: begin
        if (tick) begin
          tx_cnt_d = tx_cnt_q + SUB_W'(1);
          if (tx_cnt_q == SUB_LAST) tx_st_d = IDLE;
        end
      end
      default: tx_st_d = IDLE;
    endcase
  end

  assign tx   = tx_q;
  assign busy = (tx_st_q != IDLE);

  // ---------------- receiver ----------------
  uart_state_t          rx_st_q, rx_st_d;
  logic [SUB_W-1:0]     rx_cnt_q, rx_cnt_d;
  logic [IDX_W-1:0]     rx_idx_q, rx_idx_d;
  logic [DATA_BITS-1:0] rx_sh_q, rx_sh_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_vld_q, rx_vld_d;
  logic                 rx_err_q, rx_err_d;
  logic                 rx_fall;

  assign rx_fall = rx_prev_q & ~rx_s2_q;

  always_ff @(posedge clk_xtal or posedge rst) begin
    if (rst) begin
      rx_st_q   <= IDLE;
      rx_cnt_q  <= '0;
      rx_idx_q  <= '0;
      rx_sh_q   <= '0;
      rx_data_q <= '0;
      rx_vld_q  <= 1'b0;
      rx_err_q  <= 1'b0;
    end else begin
      rx_st_q   <= rx_st_d;
      rx_cnt_q  <= rx_cnt_d;
      rx_idx_q  <= rx_idx_d;
      rx_sh_q   <= rx_sh_d;
      rx_data_q <= rx_data_d;
      rx_vld_q  <= rx_vld_d;
      rx_err_q  <= rx_err_d;
    end
  end

  // START confirms the bit at its middle; from there every 16th tick lands mid-bit.
  always_comb begin
    rx_st_d   = rx_st_q;
    rx_cnt_d  = rx_cnt_q;
    rx_idx_d  = rx_idx_q;
    rx_sh_d   = rx_sh_q;
    rx_data_d = rx_data_q;
    rx_vld_d  = 1'b0;
    rx_err_d  = rx_err_q;
    case (rx_st_q)
      IDLE: begin
        if (rx_fall) begin
          rx_st_d  = START;
          rx_cnt_d = '0;
        end
      end
      START: begin
        if (tick) begin
          rx_cnt_d = rx_cnt_q + SUB_W'(1);
          if (rx_cnt_q == SUB_MID) begin
            if (rx_s2_q) begin
              rx_st_d = IDLE;
            end else begin
              rx_st_d  = DATA;
              rx_cnt_d = '0;
              rx_idx_d = '0;
            end
          end
        end
      end
      DATA: begin
        if (tick) begin
          rx_cnt_d = rx_cnt_q + SUB_W'(1);
          if (rx_cnt_q == SUB_LAST) begin
            rx_sh_d = {rx_s2_q, rx_sh_q[DATA_BITS-1:1]};
            if (rx_idx_q == IDX_LAST) rx_st_d = STOP;
            else                      rx_idx_d = rx_idx_q + IDX_W'(1);
          end
        end
      end
      STOP: begin
        if (tick) begin
          rx_cnt_d = rx_cnt_q + SUB_W'(1);
          if (rx_cnt_q == SUB_LAST) begin
            rx_st_d = IDLE;
            if (rx_s2_q) begin
              rx_data_d = rx_sh_q;
              rx_vld_d  = 1'b1;
              rx_err_d  = 1'b0;
            end else begin
              rx_err_d = 1'b1;
            end
          end
        end
      end
      default: rx_st_d = IDLE;
    endcase
  end

  assign DataIn   = rx_data_q;
  assign rx_valid = rx_vld_q;
  assign rx_err   = rx_err_q;

endmodule

// File: tb/tb_uart_transceiver.sv
// Scoreboarded bench: line-level monitors decode tx and watch rx_valid against queued expectations.
module tb_uart_transceiver;

  localparam int unsigned CLK_HZ = 1_843_200;

  logic        clk_xtal = 1'b0;
  logic        rst;
  logic [23:0] baud;
  logic        send;
  logic [7:0]  DataOut;
  logic        rx;
  logic        tx;
  logic [7:0]  DataIn;
  logic        busy;
  logic        rx_valid;
  logic        rx_err;

  logic rx_drv;
  logic loop;
  assign rx = loop ? tx : rx_drv;

  always #5 clk_xtal = ~clk_xtal;

  uart_transceiver #(.CLK_HZ(CLK_HZ)) dut (
    .clk_xtal (clk_xtal),
    .rst      (rst),
    .baud     (baud),
    .send     (send),
    .DataOut  (DataOut),
    .rx       (rx),
    .tx       (tx),
    .DataIn   (DataIn),
    .busy     (busy),
    .rx_valid (rx_valid),
    .rx_err   (rx_err)
  );

  int n_chk = 0;
  int n_pass = 0;
  int bit_cyc = 16;
  bit mon_en = 1'b0;
  int txf_cnt = 0;
  int rxv_cnt = 0;
  logic [7:0] tx_exp[$];
  logic [7:0] rx_exp[$];
  logic [7:0] last_good = 8'h00;
  logic       err_m = 1'b0;
  logic [7:0] tm_got;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    n_chk++;
    if (act >= lo && act <= hi) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
  endtask

  // Ideal 8N1 line level, i cycles after the start edge, at one tick per cycle.
  function automatic logic exp_tx(input logic [7:0] b, input int i);
    if (i < 16)  return 1'b0;
    if (i < 144) return b[(i - 16) / 16];
    return 1'b1;
  endfunction

  task automatic step();
    @(posedge clk_xtal);
    #1;
  endtask

  // tx line monitor: decode each frame at mid-bit and score against tx_exp
  initial begin
    forever begin
      @(negedge clk_xtal);
      if (mon_en && tx === 1'b0) begin
        repeat (bit_cyc / 2) @(negedge clk_xtal);
        chk("tx_start_bit", 32'(tx), 0);
        for (int k = 0; k < 8; k++) begin
          repeat (bit_cyc) @(negedge clk_xtal);
          tm_got[k] = tx;
        end
        repeat (bit_cyc) @(negedge clk_xtal);
        chk("tx_stop_bit", 32'(tx), 1);
        txf_cnt++;
        if (tx_exp.size() == 0) chk("tx_unexpected_frame", 1, 0);
        else                    chk("tx_byte", 32'(tm_got), 32'(tx_exp.pop_front()));
      end
    end
  end

  // rx_valid monitor
  initial begin
    forever begin
      @(negedge clk_xtal);
      if (rx_valid === 1'b1) begin
        rxv_cnt++;
        if (rx_exp.size() == 0) chk("rx_unexpected_valid", 1, 0);
        else                    chk("rx_data", 32'(DataIn), 32'(rx_exp.pop_front()));
        chk("rx_err_on_valid", 32'(rx_err), 0);
        @(negedge clk_xtal);
        chk("rx_valid_width", 32'(rx_valid), 0);
      end
    end
  end

  task automatic start_send(input logic [7:0] b, input bit push, output int lat);
    step();
    DataOut = b;
    send    = 1'b1;
    if (push) begin
      tx_exp.push_back(b);
      if (loop) rx_exp.push_back(b);
    end
    lat = 0;
    while (busy !== 1'b1 && lat < 50) begin
      @(posedge clk_xtal);
      lat++;
      #1;
    end
    send = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 5000) begin
      @(negedge clk_xtal);
      n++;
    end
    chk("tx_idle_reached", 32'(busy), 0);
  endtask

  // Sends b and compares the whole frame cycle by cycle; cycles without baud do not advance the model.
  task automatic send_rec(input logic [7:0] b);
    int lat, bad, i, guard;
    bit act;
    start_send(b, mon_en, lat);
    chk("send_to_tx_latency", lat, 3);
    @(negedge clk_xtal);
    chk("tx_fall", 32'(tx), 0);
    chk("busy_with_tx_fall", 32'(busy), 1);
    bad = 0;
    i = 1;
    guard = 0;
    act = (baud != 0);
    while (i < 161 && guard < 2000) begin
      @(negedge clk_xtal);
      guard++;
      if (act) begin
        if (i < 160) begin
          if (tx !== exp_tx(b, i)) bad++;
          if (busy !== 1'b1) bad++;
        end else begin
          chk("busy_fall_after_160", 32'(busy), 0);
        end
        i++;
      end
      act = (baud != 0);
    end
    chk("tx_waveform_errors", bad, 0);
    chk("frame_completed", i, 161);
  endtask

  task automatic rx_bb(input logic [7:0] b, input logic stop_v);
    logic [9:0] fr;
    fr = {stop_v, b, 1'b0};
    step();
    for (int k = 0; k < 10; k++) begin
      rx_drv = fr[k];
      repeat (bit_cyc) step();
    end
    rx_drv = 1'b1;
    repeat (2 * bit_cyc) step();
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat, bad, rxv0, txf0, kind, hi, n, nd;
    logic [7:0] b1, b2;
    logic ftx, fb;
    bit bad_stop;

    rst = 1'b1; baud = 24'd115200; send = 1'b0; DataOut = 8'h00; rx_drv = 1'b1; loop = 1'b0;
    repeat (3) @(posedge clk_xtal);
    @(negedge clk_xtal);
    chk("rst_tx", 32'(tx), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_datain", 32'(DataIn), 0);
    chk("rst_rx_valid", 32'(rx_valid), 0);
    chk("rst_rx_err", 32'(rx_err), 0);
    step();
    rst = 1'b0;
    mon_en = 1'b1;

    bad = 0; rxv0 = rxv_cnt;
    repeat (1000) begin
      @(negedge clk_xtal);
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    chk("idle_line_errors", bad, 0);
    chk("idle_rx_valid_count", rxv_cnt - rxv0, 0);
    chk("idle_datain", 32'(DataIn), 0);

    txf0 = txf_cnt;
    send_rec(8'hA5);
    bad = 0;
    repeat (64) begin
      @(negedge clk_xtal);
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    chk("no_second_frame", bad, 0);
    chk("one_frame_sent", txf_cnt - txf0, 1);

    loop = 1'b1; rxv0 = rxv_cnt;
    start_send(8'h3C, 1'b1, lat);
    wait_idle();
    repeat (20) step();
    loop = 1'b0;
    chk("loop_rx_valid_count", rxv_cnt - rxv0, 1);
    chk("loop_datain", 32'(DataIn), 32'h3C);
    chk("loop_rx_err", 32'(rx_err), 0);

    rxv0 = rxv_cnt;
    rx_bb(8'h81, 1'b0);
    chk("bad_stop_err", 32'(rx_err), 1);
    chk("bad_stop_datain_kept", 32'(DataIn), 32'h3C);
    chk("bad_stop_no_valid", rxv_cnt - rxv0, 0);
    rx_exp.push_back(8'h55);
    rx_bb(8'h55, 1'b1);
    chk("good_after_bad_datain", 32'(DataIn), 32'h55);
    chk("good_after_bad_err", 32'(rx_err), 0);
    chk("good_after_bad_valid", rxv_cnt - rxv0, 1);

    rxv0 = rxv_cnt;
    step(); rx_drv = 1'b0;
    repeat (4) step();
    rx_drv = 1'b1;
    repeat (40) step();
    chk("glitch_no_valid", rxv_cnt - rxv0, 0);
    chk("glitch_no_err", 32'(rx_err), 0);
    chk("glitch_datain", 32'(DataIn), 32'h55);
    last_good = 8'h55; err_m = 1'b0;

    for (int it = 0; it < 12; it++) begin
      kind = $urandom_range(0, 2);
      b1 = 8'($urandom);
      b2 = 8'($urandom);
      case (kind)
        0: begin
          loop = 1'b1;
          start_send(b1, 1'b1, lat);
          wait_idle();
          repeat (20) step();
          loop = 1'b0;
          last_good = b1; err_m = 1'b0;
        end
        1: begin
          bad_stop = ($urandom_range(0, 3) == 0);
          if (!bad_stop) rx_exp.push_back(b1);
          rx_bb(b1, !bad_stop);
          if (bad_stop) err_m = 1'b1;
          else begin last_good = b1; err_m = 1'b0; end
        end
        default: begin
          rx_exp.push_back(b2);
          fork
            begin start_send(b1, 1'b1, lat); wait_idle(); end
            rx_bb(b2, 1'b1);
          join
          last_good = b2; err_m = 1'b0;
        end
      endcase
      repeat (20) step();
      chk("rand_datain", 32'(DataIn), 32'(last_good));
      chk("rand_rx_err", 32'(rx_err), 32'(err_m));
    end
    chk("tx_scoreboard_drained", tx_exp.size(), 0);
    chk("rx_scoreboard_drained", rx_exp.size(), 0);

    mon_en = 1'b0;
    fork
      send_rec(8'h0F);
      begin
        repeat (45) @(posedge clk_xtal);
        #1 baud = 24'd0;
        @(negedge clk_xtal);
        ftx = tx; fb = busy; nd = 0;
        repeat (100) begin
          @(negedge clk_xtal);
          if (tx !== ftx || busy !== fb) nd++;
        end
        chk("freeze_changes", nd, 0);
        chk("freeze_busy", 32'(fb), 1);
        @(posedge clk_xtal);
        #1 baud = 24'd115200;
      end
    join
    wait_idle();

    start_send(8'h00, 1'b0, lat);
    repeat (70) step();
    chk("pre_rst_tx_low", 32'(tx), 0);
    rst = 1'b1;
    #1;
    chk("rst_mid_tx", 32'(tx), 1);
    chk("rst_mid_busy", 32'(busy), 0);
    repeat (2) step();
    rst = 1'b0;

    baud = 24'd9600; bit_cyc = 192; mon_en = 1'b1;
    repeat (4) step();
    b1 = {5'($urandom), 3'b010};
    start_send(b1, 1'b1, lat);
    chk("send_to_tx_latency_9600", lat, 3);
    n = 0;
    while (tx !== 1'b1 && n < 800) begin @(negedge clk_xtal); n++; end
    hi = 0;
    while (tx === 1'b1 && hi < 400) begin @(negedge clk_xtal); hi++; end
    chk_rng("bit_period_9600", hi, 191, 193);
    wait_idle();
    repeat (40) step();
    chk("tx_scoreboard_9600", tx_exp.size(), 0);

    mon_en = 1'b0;
    start_send(8'h00, 1'b0, lat);
    repeat (500) step();
    chk("pre_rst_busy_9600", 32'(busy), 1);
    rst = 1'b1;
    #1;
    chk("rst_mid_tx_9600", 32'(tx), 1);
    chk("rst_mid_busy_9600", 32'(busy), 0);
    repeat (2) step();
    rst = 1'b0;
    repeat (4) step();
    chk("post_rst_datain", 32'(DataIn), 0);
    chk("post_rst_rx_err", 32'(rx_err), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
